// File: rtl/btn_digit_counter.sv
// Bank of DIGITS push-button radix-RADIX digit counters with synchronisers, debouncers and press detect.
// Optional CARRY_CHAIN_EN macro: ripple carry/borrow between digits so the bank counts as one number.
module btn_digit_counter #(
    parameter int DIGITS          = 4,
    parameter int DIGIT_W         = 4,
    parameter int RADIX           = 16,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIGITS-1:0]           btn,
    input  logic                        dir,
    input  logic                        clr,
    output logic [DIGITS*DIGIT_W-1:0]   num,
    output logic [DIGITS-1:0]           press,
    output logic                        ovf
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int SW = DIGIT_W + 2;
    localparam logic [SW-1:0] RADIX_W = SW'(RADIX);

    logic [DIGITS-1:0] sync1;
    logic [DIGITS-1:0] sync2;
    logic [DIGITS-1:0] level;
    logic [DIGITS-1:0] level_d;
    logic [CNT_W-1:0]  cnt [DIGITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            press   <= '0;
            for (int i = 0; i < DIGITS; i++) cnt[i] <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            for (int i = 0; i < DIGITS; i++) begin
                // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [DIGITS*DIGIT_W-1:0] num_next;
    logic [SW-1:0]             cur;
    logic [SW-1:0]             amt;
    logic [SW-1:0]             nxt;
    logic                      cy;

    always_comb begin
        num_next = num;
        cur      = '0;
        amt      = '0;
        nxt      = '0;
        cy       = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            cur = SW'(num[i*DIGIT_W +: DIGIT_W]);
`ifdef CARRY_CHAIN_EN
            amt = SW'(press[i]) + SW'(cy);
`else
            amt = SW'(press[i]);
`endif
            cy = 1'b0;
            if (!dir) begin
                if (cur + amt >= RADIX_W) begin
                    nxt = cur + amt - RADIX_W;
                    cy  = 1'b1;
                end else begin
                    nxt = cur + amt;
                end
            end else begin
                if (cur >= amt) begin
                    nxt = cur - amt;
                end else begin
                    nxt = cur + RADIX_W - amt;
                    cy  = 1'b1;
                end
            end
            num_next[i*DIGIT_W +: DIGIT_W] = nxt[DIGIT_W-1:0];
        end
    end

    // After the loop cy holds the wrap of the top digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            num <= '0;
            ovf <= 1'b0;
        end else begin
            num <= num_next;
            ovf <= cy;
        end
    end

endmodule

// File: tb/tb_btn_digit_counter.sv
// Directed bench for btn_digit_counter: a hex bank and a BCD bank, both with DEBOUNCE_CYCLES=4.
module tb_btn_digit_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  btn16, btn10;
    logic        dir;
    logic        clr16, clr10;
    logic [15:0] num16, num10;
    logic [3:0]  press16, press10;
    logic        ovf16, ovf10;

    btn_digit_counter #(.DIGITS(4), .DIGIT_W(4), .RADIX(16), .DEBOUNCE_CYCLES(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .btn(btn16), .dir(dir), .clr(clr16),
        .num(num16), .press(press16), .ovf(ovf16));

    btn_digit_counter #(.DIGITS(4), .DIGIT_W(4), .RADIX(10), .DEBOUNCE_CYCLES(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .btn(btn10), .dir(dir), .clr(clr10),
        .num(num10), .press(press10), .ovf(ovf10));

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int pcount16 = 0;
    int pcount10 = 0;

    always @(negedge clk) begin
        pcount16 += $countones(press16);
        pcount10 += $countones(press10);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        bit         sel;
        logic [3:0] b;
        logic       d;
        logic       c;
        logic [15:0] en;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit sel, logic [3:0] b, logic d, logic c, logic [15:0] en, logic eo);
        vec_t v;
        v.sel = sel; v.b = b; v.d = d; v.c = c; v.en = en; v.eo = eo;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        bit found;
        logic [3:0] pr;
        found = 1'b0;
        dir = v.d;
        if (v.sel) btn10 = v.b; else btn16 = v.b;
        for (int j = 0; j < 30 && !found; j++) begin
            @(posedge clk); #1;
            pr = v.sel ? press10 : press16;
            if (pr != 4'b0) found = 1'b1;
        end
        if (!found) begin
            checks++;
            $display("FAIL vec%0d_press_timeout: got no press expected %b", idx, v.b);
        end else begin
            check($sformatf("vec%0d_press", idx), 32'(pr), 32'(v.b));
        end
        if (v.sel) clr10 = v.c; else clr16 = v.c;
        @(posedge clk); #1;
        check($sformatf("vec%0d_num", idx), 32'(v.sel ? num10 : num16), 32'(v.en));
        check($sformatf("vec%0d_ovf", idx), 32'(v.sel ? ovf10 : ovf16), 32'(v.eo));
        clr10 = 1'b0; clr16 = 1'b0;
        @(posedge clk); #1;
        check($sformatf("vec%0d_ovf_pulse", idx), 32'(v.sel ? ovf10 : ovf16), 32'd0);
        btn10 = 4'b0; btn16 = 4'b0;
        repeat (15) @(posedge clk);
        #1;
    endtask

    initial begin
        bit bad;
        int p0;

        // hex bank (sel 0), state 0 at start
        vecs.push_back(mk(0, 4'b0010, 1, 0,
`ifdef CARRY_CHAIN_EN
            16'hFFF0, 1));
`else
            16'h00F0, 0));
`endif
        vecs.push_back(mk(0, 4'b0010, 0, 0,
`ifdef CARRY_CHAIN_EN
            16'h0000, 1));
        vecs.push_back(mk(0, 4'b1000, 0, 0, 16'h1000, 0));
        vecs.push_back(mk(0, 4'b0001, 1, 0, 16'h0FFF, 0));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 16'h1000, 0));
        vecs.push_back(mk(0, 4'b0001, 0, 1, 16'h0000, 0));
        vecs.push_back(mk(0, 4'b1000, 0, 0, 16'h1000, 0));
        vecs.push_back(mk(0, 4'b0001, 1, 0, 16'h0FFF, 0));
        vecs.push_back(mk(0, 4'b0011, 0, 0, 16'h1010, 0));
`else
            16'h0000, 0));
        vecs.push_back(mk(0, 4'b0111, 1, 0, 16'h0FFF, 0));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 16'h0FF0, 0));
        vecs.push_back(mk(0, 4'b0001, 0, 1, 16'h0000, 0));
        vecs.push_back(mk(0, 4'b0111, 1, 0, 16'h0FFF, 0));
        vecs.push_back(mk(0, 4'b0011, 0, 0, 16'h0F00, 0));
`endif
        // BCD bank (sel 1): ten steps up on digit 3, then clear and borrow cases
        for (int k = 1; k <= 9; k++)
            vecs.push_back(mk(1, 4'b1000, 0, 0, 16'(k) << 12, 0));
        vecs.push_back(mk(1, 4'b1000, 0, 0, 16'h0000, 1));
        vecs.push_back(mk(1, 4'b1000, 0, 1, 16'h0000, 0));
        vecs.push_back(mk(1, 4'b1000, 1, 0, 16'h9000, 1));
`ifdef CARRY_CHAIN_EN
        vecs.push_back(mk(1, 4'b0001, 1, 0, 16'h8999, 0));
`else
        vecs.push_back(mk(1, 4'b0001, 1, 0, 16'h9009, 0));
`endif

        rst_n = 1'b0; btn16 = '0; btn10 = '0; dir = 1'b0; clr16 = 1'b0; clr10 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_num", 32'(num16), 32'h0);
        check("reset_press_ovf", 32'({press16, ovf16}), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        bad = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (num16 != 0 || press16 != 0 || ovf16 || num10 != 0 || press10 != 0 || ovf10) bad = 1'b1;
        end
        check("reset_hold_50", 32'(bad), 32'd0);

        // latency: held from before edge k, press after k+6, num after k+7
        @(negedge clk); btn16 = 4'b0001;
        @(posedge clk);
        bad = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk); #1;
            if (press16 != 0) bad = 1'b1;
        end
        check("latency_no_early_press", 32'(bad), 32'd0);
        @(posedge clk); #1;
        check("latency_press_k6", 32'(press16), 32'h1);
        check("latency_num_k6", 32'(num16), 32'h0);
        @(posedge clk); #1;
        check("latency_press_k7", 32'(press16), 32'h0);
        check("latency_num_k7", 32'(num16), 32'h0001);
        p0 = pcount16;
        repeat (100) @(posedge clk);
        #1;
        check("hold_num", 32'(num16), 32'h0001);
        check("hold_no_repress", 32'(pcount16 - p0), 32'd0);
        btn16 = 4'b0;
        repeat (20) @(posedge clk);
        #1;

        // 3-cycle glitch on btn[1]
        p0 = pcount16;
        btn16 = 4'b0010;
        repeat (3) @(posedge clk);
        #1; btn16 = 4'b0;
        repeat (20) @(posedge clk);
        #1;
        check("glitch_no_press", 32'(pcount16 - p0), 32'd0);
        check("glitch_num", 32'(num16), 32'h0001);

        clr16 = 1'b1;
        @(posedge clk); #1;
        clr16 = 1'b0;
        check("clr_num", 32'(num16), 32'h0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // reset mid-debounce discards the pending press
        btn16 = 4'b0100;
        repeat (3) @(posedge clk);
        #1;
        p0 = pcount16;
        rst_n = 1'b0;
        #1;
        check("midreset_num", 32'(num16), 32'h0);
        btn16 = 4'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midreset_no_press", 32'(pcount16 - p0), 32'd0);
        check("midreset_num_after", 32'(num16), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
